// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } feed_state_t;

    // Beats needed after the last row to drain the diagonal skew.
    function automatic int flush_beats(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One skew lane: an enabled delay line of Delay stages with a companion
// valid bit per stage. Delay 0 degenerates to a plain wire.
module skew_lane #(
    parameter int BitSize = 8,
    parameter int Delay   = 1
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic               clr,
    input  logic [BitSize-1:0] d,
    input  logic               v,
    output logic [BitSize-1:0] q,
    output logic               qv
);

    generate
        if (Delay == 0) begin : g_wire
            assign q  = d;
            assign qv = v;
            logic unused_lane_ok;
            assign unused_lane_ok = &{1'b0, clk, res, en, clr};
        end else begin : g_delay
            logic [BitSize-1:0] stage_reg [Delay];
            logic [Delay-1:0]   valid_reg;

            // Shift data and valid one stage per advance; reset or clear empties the line.
            always_ff @(posedge clk) begin
                if (res || clr) begin
                    for (int i = 0; i < Delay; i++) begin
                        stage_reg[i] <= '0;
                    end
                    valid_reg <= '0;
                end else if (en) begin
                    stage_reg[0] <= d;
                    valid_reg[0] <= v;
                    for (int i = 1; i < Delay; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                        valid_reg[i] <= valid_reg[i-1];
                    end
                end
            end

            assign q  = stage_reg[Delay-1];
            assign qv = valid_reg[Delay-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder for systolic_array: lane k delays row element k by
// k beats, and a flush tail drains the skew after the final row.
// Optional build macro SKEW_FEEDER_ZERO_FILL_EN: unmasked lanes read 0 and
// the delay lines are cleared whenever the feeder returns to IDLE.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 2
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [NumOfInputs*BitSize-1:0] in_data,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic                           out_start,
    output logic [NumOfInputs*BitSize-1:0] out_data,
    output logic [NumOfInputs-1:0]         out_lane_mask
);

    localparam int CntW = (NumOfInputs > 2) ? $clog2(NumOfInputs - 1) : 1;
    localparam logic [CntW-1:0] FlushLast = CntW'(flush_beats(NumOfInputs) - 1);
    // With a single lane there is no skew to drain, so the last row closes the matrix.
    localparam feed_state_t AfterLast = (NumOfInputs > 1) ? FLUSH : IDLE;

    feed_state_t     state_reg;
    logic [CntW-1:0] flush_cnt_reg;

    logic is_flush;
    logic accept;
    logic adv;
    logic flush_done;
    logic lane_clr;

    assign is_flush   = (state_reg == FLUSH);
    assign in_ready   = !res && out_ready && !is_flush;
    assign accept     = in_valid && in_ready;
    assign adv        = out_ready && (accept || is_flush);
    assign flush_done = is_flush && out_ready && (flush_cnt_reg == FlushLast);
    assign out_valid  = !res && (accept || is_flush);
    assign out_start  = accept && (state_reg == IDLE);

`ifdef SKEW_FEEDER_ZERO_FILL_EN
    assign lane_clr = flush_done;
`else
    assign lane_clr = 1'b0;
`endif

    // Matrix framing: open on first accept, drain the skew after the last row.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= in_last ? AfterLast : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && in_last) begin
                        state_reg <= AfterLast;
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        if (flush_cnt_reg == FlushLast) begin
                            state_reg     <= IDLE;
                            flush_cnt_reg <= '0;
                        end else begin
                            flush_cnt_reg <= flush_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    flush_cnt_reg <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumOfInputs; gi++) begin : g_lane
            logic [BitSize-1:0] lane_in;
            logic [BitSize-1:0] lane_out;
            logic               lane_v;

            // Flush beats push zeros so nothing from the last row is duplicated.
            assign lane_in = is_flush ? '0 : in_data[(NumOfInputs-1-gi)*BitSize +: BitSize];

            skew_lane #(
                .BitSize (BitSize),
                .Delay   (gi)
            ) u_lane (
                .clk (clk),
                .res (res),
                .en  (adv),
                .clr (lane_clr),
                .d   (lane_in),
                .v   (accept),
                .q   (lane_out),
                .qv  (lane_v)
            );

            assign out_lane_mask[gi] = lane_v;
`ifdef SKEW_FEEDER_ZERO_FILL_EN
            assign out_data[(NumOfInputs-1-gi)*BitSize +: BitSize] = lane_out & {BitSize{lane_v}};
`else
            assign out_data[(NumOfInputs-1-gi)*BitSize +: BitSize] = lane_out;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder with four lanes.
module tb_systolic_skew_feeder;

    localparam int N = 4;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           res;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [N*B-1:0] in_data;
    logic           out_ready;
    logic           out_valid;
    logic           out_start;
    logic [N*B-1:0] out_data;
    logic [N-1:0]   out_lane_mask;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .BitSize     (B),
        .NumOfInputs (N)
    ) dut (
        .clk           (clk),
        .res           (res),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .in_data       (in_data),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_start     (out_start),
        .out_data      (out_data),
        .out_lane_mask (out_lane_mask)
    );

    typedef struct packed {
        logic [N-1:0]   mask;
        logic           start;
        logic [N*B-1:0] data;
    } beat_t;

    typedef struct packed {
        logic           vld;
        logic [N*B-1:0] row;
        beat_t          exp;
    } vec_t;

    beat_t          sb[$];
    vec_t           tbl [7];
    logic [N*B-1:0] mat [8];
    int             total = 0;
    int             bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare the live beat with an expected one; data only under the mask
    // unless zero fill is built in, in which case every lane is defined.
    task automatic check_beat(input string name, input beat_t e);
        logic [N*B-1:0] em;
        em = '0;
        for (int k = 0; k < N; k++) begin
`ifdef SKEW_FEEDER_ZERO_FILL_EN
            em[(N-1-k)*B +: B] = '1;
`else
            if (e.mask[k]) em[(N-1-k)*B +: B] = '1;
`endif
        end
        check({name, "_data"},  64'(out_data & em), 64'(e.data & em));
        check({name, "_mask"},  64'(out_lane_mask), 64'(e.mask));
        check({name, "_start"}, 64'(out_start),     64'(e.start));
    endtask

    // Reference skew: beat b lane k carries row b-k element k.
    task automatic push_model(input int m);
        beat_t e;
        for (int b = 0; b < m + N - 1; b++) begin
            e = '0;
            e.start = (b == 0);
            for (int k = 0; k < N; k++) begin
                if (b - k >= 0 && b - k < m) begin
                    e.mask[k] = 1'b1;
                    e.data[(N-1-k)*B +: B] = mat[b-k][(N-1-k)*B +: B];
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic pop_and_check(input int b);
        beat_t e;
        if (sb.size() == 0) begin
            check("unexpected_beat", 64'(out_valid), 64'(0));
        end else begin
            e = sb.pop_front();
            check_beat("beat", e);
            $display("beat %0d data=%h mask=%b start=%b", b, out_data, out_lane_mask, out_start);
        end
    endtask

    // Feed an m-row matrix from mat[], optionally stalling out_ready for two
    // cycles at beat s1 and at beat s2 (-1 = no stall).
    task automatic run_matrix(input int m, input int s1, input int s2);
        int r = 0, b = 0, cyc = 0, stall_left = 0, stalls;
        bit d1 = 0, d2 = 0;
        stalls = ((s1 >= 0) ? 2 : 0) + ((s2 >= 0) ? 2 : 0);
        while (b < m + N - 1 && cyc < 200) begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else if (b == s1 && !d1) begin
                d1 = 1; out_ready = 1'b0; stall_left = 1;
            end else if (b == s2 && !d2) begin
                d2 = 1; out_ready = 1'b0; stall_left = 1;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (r < m);
            in_data  = (r < m) ? mat[r] : '0;
            in_last  = (r == m - 1);
            @(negedge clk);
            cyc++;
            if (!out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                if (b >= m && sb.size() > 0) begin
                    check("stall_flush_valid", 64'(out_valid), 64'(1));
                    check_beat("stall_hold", sb[0]);
                end
            end else if (b >= m) begin
                check("flush_in_ready", 64'(in_ready), 64'(0));
            end
            if (in_valid && in_ready) r++;
            if (out_valid && out_ready) begin
                pop_and_check(b);
                b++;
            end
        end
        check("matrix_beats", 64'(b), 64'(m + N - 1));
        check("matrix_cycles", 64'(cyc), 64'(m + N - 1 + stalls));
        $display("matrix rows=%0d beats=%0d cycles=%0d", m, b, cyc);
    endtask

    initial begin
        // Table: rows of the 4x4 matrix and the seven expected diagonal beats.
        tbl[0] = '{1'b1, 32'h00010203, '{4'b0001, 1'b1, 32'h00000000}};
        tbl[1] = '{1'b1, 32'h10111213, '{4'b0011, 1'b0, 32'h10010000}};
        tbl[2] = '{1'b1, 32'h20212223, '{4'b0111, 1'b0, 32'h20110200}};
        tbl[3] = '{1'b1, 32'h30313233, '{4'b1111, 1'b0, 32'h30211203}};
        tbl[4] = '{1'b0, 32'h0,        '{4'b1110, 1'b0, 32'h00312213}};
        tbl[5] = '{1'b0, 32'h0,        '{4'b1100, 1'b0, 32'h00003223}};
        tbl[6] = '{1'b0, 32'h0,        '{4'b1000, 1'b0, 32'h00000033}};

        res = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_start", 64'(out_start), 64'(0));
        @(posedge clk); #1;
        res = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_mask",      64'(out_lane_mask), 64'(0));
        check("idle_out_valid", 64'(out_valid),     64'(0));
        check("idle_in_ready",  64'(in_ready),      64'(1));

        // Test 1: table-driven 4x4, no stalls.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].vld) mat[i] = tbl[i].row;
            sb.push_back(tbl[i].exp);
        end
        run_matrix(4, -1, -1);

        // Test 2: same matrix, stalls at beat 2 and beat 5.
        push_model(4);
        run_matrix(4, 2, 5);

        // Test 3: single-row matrix.
        mat[0] = 32'hAABBCCDD;
        push_model(1);
        run_matrix(1, -1, -1);

        // Test 4: back-to-back two-row matrices, no idle gap allowed.
        mat[0] = 32'h41424344; mat[1] = 32'h51525354;
        push_model(2);
        run_matrix(2, -1, -1);
        mat[0] = 32'h61626364; mat[1] = 32'h71727374;
        push_model(2);
        run_matrix(2, -1, -1);

        // Test 5: reset pulsed on flush beat 1 of a two-row matrix.
        mat[0] = 32'h81828384; mat[1] = 32'h91929394;
        push_model(2);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (c < 2);
            in_data   = (c < 2) ? mat[c] : '0;
            in_last   = (c == 1);
            @(negedge clk);
            check("pre_rst_valid", 64'(out_valid), 64'(1));
            pop_and_check(c);
        end
        @(posedge clk); #1;
        res = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk);
        check("post_rst_valid",    64'(out_valid),     64'(0));
        check("post_rst_mask",     64'(out_lane_mask), 64'(0));
        check("post_rst_in_ready", 64'(in_ready),      64'(1));
        sb.delete();
        mat[0] = 32'hA1A2A3A4; mat[1] = 32'hB1B2B3B4; mat[2] = 32'hC1C2C3C4;
        push_model(3);
        run_matrix(3, -1, -1);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
